ped_signal_ctrl: RTL
====================

# ped_signal_ctrl

Pedestrian-crossing controller downstream of the north-approach traffic-light FSM. Consumes the FSM's one-hot lamp outputs (N_R/N_Y/N_G), latches pedestrian button requests, and grants a walk phase only at the start of a vehicle red. Drives the walk / flashing-don't-walk lamps and a countdown display. Flags illegal lamp combinations and red phases too short for a full walk.

## Interface
- WALK_CYCLES, 8: steady WALK duration in clock cycles; legal range 1..2^CNT_W-1.
- FLASH_CYCLES, 6: flashing don't-walk duration in cycles; legal range 1..2^CNT_W-1.
- CNT_W, 4: width of the timer and the countdown output.

- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- N_R  in  1  vehicle red lamp from the traffic FSM.
- N_Y  in  1  vehicle yellow lamp.
- N_G  in  1  vehicle green lamp.
- ped_btn  in  1  pedestrian request, synchronous, level-sampled every cycle.
- walk  out  1  WALK lamp.
- dont_walk  out  1  DON'T WALK lamp; steady or flashing.
- countdown  out  CNT_W  remaining FLASH cycles; 0 outside FLASH.
- req_pending  out  1  a request is latched and not yet served.
- viol  out  1  one-cycle pulse: red ended during WALK/FLASH.
- fault  out  1  sticky: illegal lamp combination detected.

## Operation
- Input stage: N_R/N_Y/N_G registered into r_q/y_q/g_q, then r_q into r_qq.
- Red onset: r_q & ~r_qq.
- Legality check: exactly one of r_q/y_q/g_q set. It is enabled only once vld is set; vld sets on the first edge after reset release.
- States are IDLE, WALK, FLASH and FAULT. The state type lives in the package.
- IDLE: walk=0, dont_walk=1, countdown=0.
  - If red onset and (req_pending | ped_btn): go to WALK, load timer with WALK_CYCLES-1, clear req_pending.
  - Else if ped_btn: set req_pending.
  - A request made while red is already on waits for the next red onset.
- WALK: walk=1, dont_walk=0. ped_btn is ignored.
  - Timer decrements each cycle.
  - At timer==0: go to FLASH, set countdown=FLASH_CYCLES.
- FLASH: walk=0.
  - dont_walk=1 on the first FLASH cycle, then toggles every cycle.
  - countdown decrements each cycle.
  - When countdown==1: go to IDLE next edge (countdown→0, dont_walk=1).
  - ped_btn is ignored.
- Violation: r_q=0 while in WALK or FLASH.
  - Go to IDLE next edge and pulse viol for exactly one cycle.
  - req_pending stays 0.
- FAULT: entered from any state when the legality check fails (vld=1). Fault has priority over every other transition.
  - Outputs: walk=0, dont_walk=1 steady, countdown=0, fault=1, req_pending=0.
  - Exit only by rst.
- Reset values:
  - State and registers: state=IDLE, r_q=y_q=g_q=0, r_qq=1, vld=0, timer=0.
  - Outputs: walk=0, dont_walk=1, countdown=0, req_pending=0, viol=0, fault=0.
  - r_qq=1 means a red already present at reset release is never treated as an onset.
- Reset asserted mid-WALK or mid-FLASH: outputs return to reset values immediately (asynchronous).

## Timing
- All outputs are registered. No combinational input→output path.
- N_R rises before edge k: r_q=1 after edge k, state=WALK and walk=1 after edge k+1. Latency is 2 edges.
- WALK lasts exactly WALK_CYCLES cycles, FLASH exactly FLASH_CYCLES cycles. dont_walk returns to steady 1 after WALK_CYCLES+FLASH_CYCLES cycles.
- ped_btn high on the same cycle as red onset, with no prior request: granted.
- Illegal lamp state at inputs before edge k: fault=1 after edge k+1.
- Violation: N_R falls before edge k, r_q=0 after edge k, viol=1 and state=IDLE after edge k+1, viol=0 after edge k+2.

## Structure
- traffic_pkg holds:
  - ped_state_t enum {IDLE, WALK, FLASH, FAULT}.
  - Default parameter constants WALK_CYCLES_D=8, FLASH_CYCLES_D=6, CNT_W_D=4.
- Sub-module lamp_sampler takes clk, rst, N_R/N_Y/N_G and produces r_q, red_onset, lamp_ok and vld.
- Top level holds the FSM, timer and request latch.

## Test plan
- Reset release with N_R=1 steady, ped_btn pulsed: req_pending=1; walk stays 0 until N_R drops and rises again, then walk=1 two edges after the rise.
- Defaults, request pending, red held 20 cycles: walk=1 for 8 cycles; then dont_walk pattern 1,0,1,0,1,0 with countdown 6,5,4,3,2,1; then dont_walk=1, countdown=0; viol never asserts.
- ped_btn high on the red-onset cycle with req_pending=0: walk granted, req_pending stays 0.
- Red drops 4 cycles into WALK: viol pulses once, walk=0, dont_walk=1 steady, countdown=0.
- N_R=1 and N_G=1 together for one cycle during WALK: fault=1, walk=0, dont_walk=1; state holds through later legal inputs until rst.
- rst asserted mid-FLASH: outputs go immediately to walk=0, dont_walk=1, countdown=0, req_pending=0 without waiting for a clock edge.

Source files
------------

// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared types and default timing constants for the pedestrian controller
package traffic_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WALK  = 2'd1,
    FLASH = 2'd2,
    FAULT = 2'd3
  } ped_state_t;

  localparam int WALK_CYCLES_D  = 8;
  localparam int FLASH_CYCLES_D = 6;
  localparam int CNT_W_D        = 4;

endpackage

// File: rtl/lamp_sampler.sv
// rtl/lamp_sampler.sv - registers the vehicle lamps, detects red onset and checks one-hot legality
module lamp_sampler (
  input  logic clk,
  input  logic rst,
  input  logic N_R,
  input  logic N_Y,
  input  logic N_G,
  output logic r_q,
  output logic red_onset,
  output logic lamp_ok,
  output logic vld
);

  logic y_q;
  logic g_q;
  logic r_qq;
  logic vld_q;

  // r_qq only follows r_q once vld is up, so a red already lit at reset release is not an onset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q   <= 1'b0;
      y_q   <= 1'b0;
      g_q   <= 1'b0;
      r_qq  <= 1'b1;
      vld_q <= 1'b0;
    end else begin
      r_q   <= N_R;
      y_q   <= N_Y;
      g_q   <= N_G;
      vld_q <= 1'b1;
      if (vld_q) begin
        r_qq <= r_q;
      end
    end
  end

  assign red_onset = r_q & ~r_qq;
  assign lamp_ok   = $onehot({r_q, y_q, g_q});
  assign vld       = vld_q;

endmodule

// File: rtl/ped_signal_ctrl.sv
// rtl/ped_signal_ctrl.sv - pedestrian walk FSM, phase timer and request latch
module ped_signal_ctrl
  import traffic_pkg::*;
#(
  parameter int WALK_CYCLES  = WALK_CYCLES_D,
  parameter int FLASH_CYCLES = FLASH_CYCLES_D,
  parameter int CNT_W        = CNT_W_D
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             N_R,
  input  logic             N_Y,
  input  logic             N_G,
  input  logic             ped_btn,
  output logic             walk,
  output logic             dont_walk,
  output logic [CNT_W-1:0] countdown,
  output logic             req_pending,
  output logic             viol,
  output logic             fault
);

  logic r_q, red_onset, lamp_ok, vld;

  lamp_sampler u_lamp_sampler (
    .clk       (clk),
    .rst       (rst),
    .N_R       (N_R),
    .N_Y       (N_Y),
    .N_G       (N_G),
    .r_q       (r_q),
    .red_onset (red_onset),
    .lamp_ok   (lamp_ok),
    .vld       (vld)
  );

  ped_state_t       state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             walk_q, walk_d;
  logic             dw_q, dw_d;
  logic             req_q, req_d;
  logic             viol_q, viol_d;
  logic             fault_q, fault_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      cnt_q   <= '0;
      walk_q  <= 1'b0;
      dw_q    <= 1'b1;
      req_q   <= 1'b0;
      viol_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
      walk_q  <= walk_d;
      dw_q    <= dw_d;
      req_q   <= req_d;
      viol_q  <= viol_d;
      fault_q <= fault_d;
    end
  end

  // Outputs are computed here for the next state so every lamp comes straight from a flop
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    cnt_d   = cnt_q;
    walk_d  = walk_q;
    dw_d    = dw_q;
    req_d   = req_q;
    viol_d  = 1'b0;
    fault_d = fault_q;

    if (vld && !lamp_ok) begin
      state_d = FAULT;
      timer_d = '0;
      cnt_d   = '0;
      walk_d  = 1'b0;
      dw_d    = 1'b1;
      req_d   = 1'b0;
      fault_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          walk_d = 1'b0;
          dw_d   = 1'b1;
          cnt_d  = '0;
          if (red_onset && (req_q || ped_btn)) begin
            state_d = WALK;
            timer_d = CNT_W'(WALK_CYCLES - 1);
            req_d   = 1'b0;
            walk_d  = 1'b1;
            dw_d    = 1'b0;
          end else if (ped_btn) begin
            req_d = 1'b1;
          end
        end
        WALK, FLASH: begin
          if (!r_q) begin
            state_d = IDLE;
            viol_d  = 1'b1;
            walk_d  = 1'b0;
            dw_d    = 1'b1;
            cnt_d   = '0;
            req_d   = 1'b0;
          end else if (state_q == WALK) begin
            if (timer_q == '0) begin
              state_d = FLASH;
              cnt_d   = CNT_W'(FLASH_CYCLES);
              walk_d  = 1'b0;
              dw_d    = 1'b1;
            end else begin
              timer_d = timer_q - CNT_W'(1);
            end
          end else if (cnt_q == CNT_W'(1)) begin
            state_d = IDLE;
            cnt_d   = '0;
            dw_d    = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
            dw_d  = ~dw_q;
          end
        end
        default: begin
          state_d = FAULT;
        end
      endcase
    end
  end

  assign walk        = walk_q;
  assign dont_walk   = dw_q;
  assign countdown   = cnt_q;
  assign req_pending = req_q;
  assign viol        = viol_q;
  assign fault       = fault_q;

endmodule
